// File: rtl/esp_resp_parser_if.sv
// Handshake bundle between a command sequencer and the ESP response parser.
// The sequencer drives start and the rx byte stream; the parser drives the rest.
interface esp_resp_parser_if #(
   parameter int LC_WIDTH = 8
);
   logic                start;
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic                done;
   logic [1:0]          result;
   logic                busy;
   logic [LC_WIDTH-1:0] line_count;

   modport master (
      output start, rx_data, rx_valid,
      input  rx_ready, done, result, busy, line_count
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output rx_ready, done, result, busy, line_count
   );
endinterface

// File: rtl/esp_resp_parser.sv
// Scans UART response lines from an ESP module for OK / ERROR / FAIL terminal
// lines, counting the informational lines seen before them, with a timeout.
module esp_resp_parser #(
   parameter int TIMEOUT_CYCLES = 100000000,
   parameter int LC_WIDTH       = 8
) (
   input logic               clk,
   input logic               rst,
   esp_resp_parser_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int             TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] RES_OK      = 2'b00;
   localparam logic [1:0] RES_ERROR   = 2'b01;
   localparam logic [1:0] RES_FAIL    = 2'b10;
   localparam logic [1:0] RES_TIMEOUT = 2'b11;

   // Flag bit order: [0] OK, [1] ERROR, [2] FAIL; codes match the result encoding.
   function automatic logic char_match(input logic [1:0] tok, input logic [2:0] pos,
                                       input logic [7:0] b);
      logic [7:0] exp_v;
      logic       in_range_v;
      exp_v      = 8'h00;
      in_range_v = 1'b0;
      case (tok)
         2'd0: begin
            in_range_v = (pos < 3'd2);
            case (pos)
               3'd0:    exp_v = 8'h4F;
               3'd1:    exp_v = 8'h4B;
               default: exp_v = 8'h00;
            endcase
         end
         2'd1: begin
            in_range_v = (pos < 3'd5);
            case (pos)
               3'd0:    exp_v = 8'h45;
               3'd1:    exp_v = 8'h52;
               3'd2:    exp_v = 8'h52;
               3'd3:    exp_v = 8'h4F;
               3'd4:    exp_v = 8'h52;
               default: exp_v = 8'h00;
            endcase
         end
         2'd2: begin
            in_range_v = (pos < 3'd4);
            case (pos)
               3'd0:    exp_v = 8'h46;
               3'd1:    exp_v = 8'h41;
               3'd2:    exp_v = 8'h49;
               3'd3:    exp_v = 8'h4C;
               default: exp_v = 8'h00;
            endcase
         end
         default: begin
            in_range_v = 1'b0;
            exp_v      = 8'h00;
         end
      endcase
      return in_range_v && (b == exp_v);
   endfunction

   logic [1:0]          state_r, state_n_s;
   logic [2:0]          pos_r, pos_n_s;
   logic [2:0]          flag_r, flag_n_s;
   logic [TW-1:0]       timer_r, timer_n_s;
   logic [LC_WIDTH-1:0] lc_cnt_r, lc_cnt_n_s;
   logic [LC_WIDTH-1:0] line_count_r, line_count_n_s;
   logic [1:0]          result_r, result_n_s;
   logic                done_r;
   logic                busy_r;
   logic                rx_ready_s;
   logic                accept_s;
   logic                is_cr_s;
   logic                is_lf_s;
   logic                match_s;
   logic [1:0]          match_code_s;

   assign rx_ready_s = !rst && (state_r != ST_DONE);
   assign accept_s   = bus.rx_valid && rx_ready_s;
   assign is_cr_s    = (bus.rx_data == 8'h0D);
   assign is_lf_s    = (bus.rx_data == 8'h0A);

   assign bus.rx_ready   = rx_ready_s;
   assign bus.done       = done_r;
   assign bus.busy       = busy_r;
   assign bus.result     = result_r;
   assign bus.line_count = line_count_r;

   // Next-state, line matcher and result capture.
   always_comb begin
      state_n_s      = state_r;
      pos_n_s        = pos_r;
      flag_n_s       = flag_r;
      timer_n_s      = timer_r;
      lc_cnt_n_s     = lc_cnt_r;
      line_count_n_s = line_count_r;
      result_n_s     = result_r;
      match_s        = 1'b0;
      match_code_s   = RES_OK;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_n_s      = ST_ARMED;
               pos_n_s        = 3'd0;
               flag_n_s       = 3'b111;
               timer_n_s      = '0;
               lc_cnt_n_s     = '0;
               line_count_n_s = '0;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_ARMED: begin
            timer_n_s = timer_r + TW'(1'b1);
            if (accept_s && is_lf_s) begin
               if (flag_r[0] && (pos_r == 3'd2)) begin
                  match_s      = 1'b1;
                  match_code_s = RES_OK;
               end else if (flag_r[1] && (pos_r == 3'd5)) begin
                  match_s      = 1'b1;
                  match_code_s = RES_ERROR;
               end else if (flag_r[2] && (pos_r == 3'd4)) begin
                  match_s      = 1'b1;
                  match_code_s = RES_FAIL;
               end else begin
                  match_s = 1'b0;
               end
               // Empty lines and terminal lines are not counted.
               if (!match_s && (pos_r != 3'd0) && (lc_cnt_r != '1)) begin
                  lc_cnt_n_s = lc_cnt_r + LC_WIDTH'(1'b1);
               end else begin
                  lc_cnt_n_s = lc_cnt_r;
               end
               pos_n_s  = 3'd0;
               flag_n_s = 3'b111;
            end else if (accept_s && !is_cr_s) begin
               flag_n_s[0] = flag_r[0] && char_match(2'd0, pos_r, bus.rx_data);
               flag_n_s[1] = flag_r[1] && char_match(2'd1, pos_r, bus.rx_data);
               flag_n_s[2] = flag_r[2] && char_match(2'd2, pos_r, bus.rx_data);
               pos_n_s     = (pos_r == 3'd7) ? pos_r : (pos_r + 3'd1);
            end else begin
               pos_n_s = pos_r;
            end
            if (match_s) begin
               state_n_s      = ST_DONE;
               result_n_s     = match_code_s;
               line_count_n_s = lc_cnt_n_s;
            end else if (timer_r == TIMER_LAST) begin
               state_n_s      = ST_DONE;
               result_n_s     = RES_TIMEOUT;
               line_count_n_s = lc_cnt_n_s;
            end else begin
               state_n_s = ST_ARMED;
            end
         end
         ST_DONE: begin
            state_n_s = ST_IDLE;
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         pos_r        <= 3'd0;
         flag_r       <= 3'b111;
         timer_r      <= '0;
         lc_cnt_r     <= '0;
         line_count_r <= '0;
         result_r     <= RES_OK;
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_n_s;
         pos_r        <= pos_n_s;
         flag_r       <= flag_n_s;
         timer_r      <= timer_n_s;
         lc_cnt_r     <= lc_cnt_n_s;
         line_count_r <= line_count_n_s;
         result_r     <= result_n_s;
         done_r       <= (state_n_s == ST_DONE);
         busy_r       <= (state_n_s == ST_ARMED);
      end
   end

endmodule

// File: tb/tb_esp_resp_parser.sv
// Scoreboard bench for esp_resp_parser: directed response streams push expected
// results; a negedge monitor checks every done pulse against the queue.
module tb_esp_resp_parser;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   typedef struct {
      logic [1:0] res;
      logic [7:0] lc;
      int         at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   esp_resp_parser_if #(.LC_WIDTH(8)) bus_if ();

   esp_resp_parser #(.TIMEOUT_CYCLES(16), .LC_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus_if.done === 1'b1) begin
         check("done_rx_ready", {31'd0, bus_if.rx_ready}, 32'd0);
         check("done_busy", {31'd0, bus_if.busy}, 32'd0);
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: result=%0d line_count=%0d, expected no done (cycle %0d)",
                     bus_if.result, bus_if.line_count, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("result", {30'd0, bus_if.result}, {30'd0, mon_e.res});
            check("line_count", {24'd0, bus_if.line_count}, {24'd0, mon_e.lc});
            check("done_cycle", cyc, mon_e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus_if.rx_data  = b;
      bus_if.rx_valid = 1'b1;
      tick();
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic send_text(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_line(input string s);
      send_text(s);
      send_byte(8'h0D);
      send_byte(8'h0A);
   endtask

   task automatic do_start();
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
   endtask

   task automatic expect_done(input logic [1:0] r, input logic [7:0] lc, input int at);
      exp_t e;
      e.res = r;
      e.lc  = lc;
      e.at  = at;
      sb.push_back(e);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() > 0 && k < 40) begin
         tick();
         k++;
      end
      check("drain_outstanding", sb.size(), 32'd0);
      sb.delete();
      tick();
      tick();
   endtask

   initial begin
      int s;
      bus_if.start    = 1'b0;
      bus_if.rx_valid = 1'b0;
      bus_if.rx_data  = 8'h00;
      rst = 1'b1;
      tick();
      check("rst_rx_ready", {31'd0, bus_if.rx_ready}, 32'd0);
      tick();
      check("rst_done", {31'd0, bus_if.done}, 32'd0);
      check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check("rst_result", {30'd0, bus_if.result}, 32'd0);
      check("rst_line_count", {24'd0, bus_if.line_count}, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);
      tick();

      // Informational line, empty line, then OK.
      do_start();
      check("armed_busy", {31'd0, bus_if.busy}, 32'd1);
      send_line("AT");
      send_line("");
      send_line("OK");
      expect_done(2'b00, 8'd1, cyc);
      drain();
      check("idle_busy", {31'd0, bus_if.busy}, 32'd0);
      check("result_hold", {30'd0, bus_if.result}, 32'd0);

      do_start();
      send_line("ERROR");
      expect_done(2'b01, 8'd0, cyc);
      drain();

      do_start();
      send_line("OKAY");
      send_line("FAIL");
      expect_done(2'b10, 8'd1, cyc);
      drain();

      // Reset after a partial "ERR" abandons the response.
      do_start();
      send_text("ERR");
      rst = 1'b1;
      #1;
      check("midrst_rx_ready", {31'd0, bus_if.rx_ready}, 32'd0);
      tick();
      check("midrst_done", {31'd0, bus_if.done}, 32'd0);
      check("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
      check("midrst_result", {30'd0, bus_if.result}, 32'd0);
      check("midrst_line_count", {24'd0, bus_if.line_count}, 32'd0);
      rst = 1'b0;
      tick();
      tick();
      do_start();
      send_line("OK");
      expect_done(2'b00, 8'd0, cyc);
      drain();

      // Timeout with no bytes: done 16 cycles after ARMED entry.
      do_start();
      expect_done(2'b11, 8'd0, cyc + 16);
      drain();

      // Terminating LF accepted on the last timer cycle: token wins.
      do_start();
      repeat (12) tick();
      send_line("OK");
      expect_done(2'b00, 8'd0, cyc);
      drain();

      // Unsolicited output in IDLE is flushed without a done.
      send_line("OK");
      tick();
      tick();
      do_start();
      send_line("FAIL");
      expect_done(2'b10, 8'd0, cyc);
      drain();

      // Unterminated partial token times out.
      do_start();
      s = cyc;
      send_text("OK");
      expect_done(2'b11, 8'd0, s + 16);
      drain();

      // Lowercase does not match; a second start while ARMED is ignored.
      do_start();
      send_line("ok");
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      send_line("OK");
      expect_done(2'b00, 8'd1, cyc);
      drain();

      // Over-long line is not a token.
      do_start();
      send_line("ERRORS");
      send_line("ERROR");
      expect_done(2'b01, 8'd1, cyc);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/esp_resp_parser.md
ESP_RESP_PARSER -- requirements
Module: esp_resp_parser

Interface
- REQ-001 Parameter TIMEOUT_CYCLES, default 100000000: maximum cycles to wait in ARMED for a terminal response line (1 s at 100 MHz).
- REQ-002 Parameter LC_WIDTH, default 8: width of line_count.
- REQ-003 clk  in  1  single clock; all logic on its rising edge.
- REQ-004 rst  in  1  synchronous reset, active-high.
- REQ-005 start  in  1  single-cycle request to arm the parser after a command has been sent.
- REQ-006 rx_data  in  8  received byte from the UART_COM rx side.
- REQ-007 rx_valid  in  1  rx_data is valid.
- REQ-008 rx_ready  out  1  parser accepts the byte this cycle; a transfer occurs when rx_valid and rx_ready are both 1.
- REQ-009 done  out  1  one-cycle pulse; result is valid.
- REQ-010 result  out  2  00 OK, 01 ERROR, 10 FAIL, 11 TIMEOUT; held until the next done.
- REQ-011 busy  out  1  high while in ARMED.
- REQ-012 line_count  out  LC_WIDTH  non-empty, non-terminal lines received since the last start; saturating.

Function
- REQ-013 The parser SHALL have three states: IDLE, ARMED and DONE.
- REQ-014 IDLE: rx_ready=1; accepted bytes are discarded (flush unsolicited output); start=1 moves to ARMED on the next cycle.
- REQ-015 On entry to ARMED: line position=0, all match flags set, timer=0, line_count=0.
- REQ-016 ARMED: rx_ready=1; the timer increments every cycle.
- REQ-017 DONE: lasts exactly one cycle; done=1, rx_ready=0; then IDLE.
- REQ-018 start SHALL be ignored in ARMED and DONE.
- REQ-019 Tokens SHALL be "OK", "ERROR" and "FAIL", matched case-sensitively against whole lines.
- REQ-020 An accepted 0x0D SHALL be ignored anywhere in a line.
- REQ-021 An accepted 0x0A SHALL terminate the line.
- REQ-022 Any other accepted byte at position p SHALL clear each token flag where p >= token length or byte != token[p]; position then increments, saturating at 7.
- REQ-023 On 0x0A, if a token flag is set and position equals that token's length, state SHALL be DONE on the next cycle with result set to the token code.
- REQ-024 On 0x0A with position=0 (empty line), nothing is counted.
- REQ-025 On 0x0A otherwise, line_count increments (saturating at all-ones).
- REQ-026 In both REQ-024 and REQ-025 cases, position resets to 0 and all flags are set.
- REQ-027 Latency: done SHALL assert exactly one cycle after the cycle in which the terminating 0x0A is accepted.
- REQ-028 Timeout: if the timer reaches TIMEOUT_CYCLES-1 in ARMED with no terminal match, the next state SHALL be DONE with result=11.
- REQ-029 If a terminating 0x0A completes a match in the same cycle as timeout, the token result SHALL win.
- REQ-030 An unterminated partial line SHALL never produce a token result.
- REQ-031 result and line_count SHALL update only on the transition into DONE or on entry to ARMED (line_count clears there), and hold otherwise.
- REQ-032 Bytes presented while in DONE SHALL not be accepted; they are consumed once rx_ready returns in IDLE.

Reset
- REQ-033 With rst=1 at a clock edge the block SHALL go to IDLE with done=0, busy=0, result=00, line_count=0, timer=0, position=0 and all flags set.
- REQ-034 rx_ready SHALL be 0 in any cycle where rst=1.
- REQ-035 Reset in mid-line or mid-ARMED SHALL abandon the response with no done pulse.

Verification
- REQ-036 start, then "AT\r\n\r\nOK\r\n" -> one done pulse one cycle after the final 0x0A, result=00, line_count=1, busy low after done.
- REQ-037 start, then "ERROR\r\n" -> result=01; start, then "OKAY\r\nFAIL\r\n" -> result=10, line_count=1.
- REQ-038 TIMEOUT_CYCLES=16, start, no bytes -> done 16 cycles after ARMED entry, result=11.
- REQ-039 TIMEOUT_CYCLES=16, final "\n" of "OK\r\n" accepted on the timeout cycle -> result=00.
- REQ-040 Bytes "OK\r\n" while IDLE -> no done; then start plus "FAIL\r\n" -> result=10, line_count=0.
- REQ-041 rst asserted after "ERR" -> outputs at reset values, no done; then start plus "OK\r\n" -> result=00.
